// File: rtl/div_issue_stage.sv
// Issue/retire stage wrapped around the combinational signed divider: holds operands for a settle window, then registers the result.
// Optional divide-by-zero trap is enabled by defining DIV_ZERO_TRAP_EN.
module div_issue_stage #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_divident,
  input  logic signed [WIDTH-1:0] in_divisor,
  output logic signed [WIDTH-1:0] div_divident,
  output logic signed [WIDTH-1:0] div_divisor,
  input  logic signed [WIDTH-1:0] div_quotient,
  input  logic signed [WIDTH-1:0] div_remainder,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_quotient,
  output logic signed [WIDTH-1:0] out_remainder,
  output logic                    out_ovf,
`ifdef DIV_ZERO_TRAP_EN
  output logic                    out_err,
`endif
  output logic                    busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             zero_div;

  function automatic logic is_ovf(input logic signed [WIDTH-1:0] a,
                                  input logic signed [WIDTH-1:0] b);
    return (a == MIN_VAL) && (b == {WIDTH{1'b1}});
  endfunction

  function automatic logic signed [WIDTH-1:0] fix_q(input logic ovf,
                                                    input logic signed [WIDTH-1:0] q);
    return ovf ? MIN_VAL : q;
  endfunction

  function automatic logic signed [WIDTH-1:0] fix_r(input logic ovf,
                                                    input logic signed [WIDTH-1:0] r);
    return ovf ? '0 : r;
  endfunction

`ifdef DIV_ZERO_TRAP_EN
  assign zero_div = (in_divisor == '0);
`else
  assign zero_div = 1'b0;
`endif

  assign accept    = (state == IDLE) && in_valid;
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = zero_div ? DONE : SETTLE;
      SETTLE:  if (cnt == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Issue: operands stay on the divider inputs until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_divident  <= '0;
      div_divisor   <= '0;
      cnt           <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_ovf       <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      out_err       <= 1'b0;
`endif
    end else if (accept) begin
      div_divident <= in_divident;
      div_divisor  <= in_divisor;
      cnt          <= CNT_W'(SETTLE_CYCLES - 1);
      out_ovf      <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      out_err      <= zero_div;
      if (zero_div) begin
        out_quotient  <= '1;
        out_remainder <= in_divident;
      end
`endif
    end else if (state == SETTLE) begin
      // Retire: capture once the divider has had the full settle window
      if (cnt == '0) begin
        out_quotient  <= fix_q(is_ovf(div_divident, div_divisor), div_quotient);
        out_remainder <= fix_r(is_ovf(div_divident, div_divisor), div_remainder);
        out_ovf       <= is_ovf(div_divident, div_divisor);
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_div_issue_stage.sv
// Self-checking bench for div_issue_stage with a behavioural divider stand-in and a truncating golden model.
module tb_div_issue_stage;
  localparam int W  = 16;
  localparam int SC = 4;
  localparam int N  = 50;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] in_divident = '0;
  logic signed [W-1:0] in_divisor = '0;
  logic signed [W-1:0] div_divident, div_divisor;
  logic signed [W-1:0] div_quotient, div_remainder;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] out_quotient, out_remainder;
  logic                out_ovf;
`ifdef DIV_ZERO_TRAP_EN
  logic                out_err;
`endif
  logic                busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_issue_stage #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_divident(in_divident), .in_divisor(in_divisor),
    .div_divident(div_divident), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_ovf(out_ovf),
`ifdef DIV_ZERO_TRAP_EN
    .out_err(out_err),
`endif
    .busy(busy)
  );

  // Divider stand-in: truncating division; distinctive junk for the cases the stage must handle itself
  always_comb begin
    div_quotient  = '0;
    div_remainder = '0;
    if (div_divisor == 0) begin
      div_quotient  = 16'sh5A5A;
      div_remainder = -16'sh5A5B;
    end else if (div_divident == -16'sd32768 && div_divisor == -16'sd1) begin
      div_quotient  = 16'sh7FFF;
      div_remainder = 16'sh0001;
    end else begin
      div_quotient  = W'(int'(div_divident) / int'(div_divisor));
      div_remainder = W'(int'(div_divident) % int'(div_divisor));
    end
  end

  task automatic issue(input int a, input int b);
    in_divident = W'(a);
    in_divisor  = W'(b);
    in_valid    = 1'b1;
    @(negedge clk);
    in_valid    = 1'b0;
  endtask

  // lat = edges after the accept edge before out_valid is seen; lowcnt = samples with in_ready low
  task automatic wait_valid(output int lat, output int lowcnt);
    lat = 0;
    lowcnt = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) lowcnt++;
      @(negedge clk);
      lat++;
    end
    if (!in_ready) lowcnt++;
  endtask

  task automatic test_reset;
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b exp 0", busy); end
    total++; if (out_quotient !== 16'sd0 || div_divident !== 16'sd0) begin
      bad++; $display("FAIL rst_regs got q=%0d dd=%0d exp 0", out_quotient, div_divident);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_release got in_ready=%b busy=%b exp 1/0", in_ready, busy);
    end
  endtask

  task automatic test_basic;
    int lat, lowcnt;
    out_ready = 1'b1;
    issue(100, 7);
    wait_valid(lat, lowcnt);
    total++; if (lat != SC) begin bad++; $display("FAIL basic_latency got %0d exp %0d", lat, SC); end
    total++; if (out_quotient !== 16'sd14) begin bad++; $display("FAIL basic_q got %0d exp 14", out_quotient); end
    total++; if (out_remainder !== 16'sd2) begin bad++; $display("FAIL basic_r got %0d exp 2", out_remainder); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got %b exp 0", out_ovf); end
    @(negedge clk);
    total++; if (lowcnt != SC + 1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_ready_low got %0d/%b/%b exp %0d/1/0", lowcnt, in_ready, out_valid, SC + 1);
    end
  endtask

  task automatic test_hold;
    int lat, lowcnt;
    out_ready = 1'b0;
    issue(-100, 7);
    wait_valid(lat, lowcnt);
    total++; if (lat != SC) begin bad++; $display("FAIL hold_latency got %0d exp %0d", lat, SC); end
    in_divident = 16'sd1234;
    in_divisor  = 16'sd3;
    in_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_quotient !== -16'sd14 ||
                   out_remainder !== -16'sd2 || div_divident !== -16'sd100) begin
        bad++; $display("FAIL hold_stable got v=%b rdy=%b q=%0d r=%0d dd=%0d exp 1/0/-14/-2/-100",
                        out_valid, in_ready, out_quotient, out_remainder, div_divident);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL hold_release got v=%b busy=%b rdy=%b exp 0/0/1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_ovf;
    int lat, lowcnt;
    out_ready = 1'b1;
    issue(-32768, -1);
    wait_valid(lat, lowcnt);
    total++; if (out_quotient !== -16'sd32768 || out_remainder !== 16'sd0 || out_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_result got q=%0d r=%0d ovf=%b exp -32768/0/1", out_quotient, out_remainder, out_ovf);
    end
    @(negedge clk);
    issue(9, -2);
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear got %b exp 0", out_ovf); end
    wait_valid(lat, lowcnt);
    total++; if (out_quotient !== -16'sd4 || out_remainder !== 16'sd1 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL ovf_next got q=%0d r=%0d ovf=%b exp -4/1/0", out_quotient, out_remainder, out_ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_zero;
    int lat, lowcnt;
    out_ready = 1'b1;
    issue(5, 0);
    wait_valid(lat, lowcnt);
`ifdef DIV_ZERO_TRAP_EN
    total++; if (lat != 0) begin bad++; $display("FAIL zero_latency got %0d exp 0", lat); end
    total++; if (out_quotient !== -16'sd1 || out_remainder !== 16'sd5 || out_err !== 1'b1) begin
      bad++; $display("FAIL zero_trap got q=%0d r=%0d err=%b exp -1/5/1", out_quotient, out_remainder, out_err);
    end
    @(negedge clk);
    issue(7, 2);
    wait_valid(lat, lowcnt);
    total++; if (out_err !== 1'b0 || out_quotient !== 16'sd3 || out_remainder !== 16'sd1) begin
      bad++; $display("FAIL zero_clear got err=%b q=%0d r=%0d exp 0/3/1", out_err, out_quotient, out_remainder);
    end
`else
    total++; if (lat != SC) begin bad++; $display("FAIL zero_latency got %0d exp %0d", lat, SC); end
    total++; if (out_quotient !== 16'sh5A5A || out_remainder !== -16'sh5A5B) begin
      bad++; $display("FAIL zero_raw got q=%0d r=%0d exp %0d/%0d", out_quotient, out_remainder, 16'sh5A5A, -16'sh5A5B);
    end
`endif
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int eq[$], er[$];
    int a, b, sent, recv, cyc, xq, xr;
    bit pend;
    sent = 0; recv = 0; cyc = 0; pend = 0;
    a = $urandom_range(400) - 200;
    do b = $urandom_range(400) - 200; while (b == 0);
    in_divident = W'(a); in_divisor = W'(b); in_valid = 1'b1;
    while (recv < N && cyc < 4000) begin
      if (pend) begin
        if (sent < N) begin
          a = $urandom_range(400) - 200;
          do b = $urandom_range(400) - 200; while (b == 0);
          in_divident = W'(a); in_divisor = W'(b);
        end else begin
          in_valid = 1'b0;
        end
      end
      pend = 0;
      if (in_valid && in_ready) begin
        eq.push_back(a / b); er.push_back(a % b);
        sent++; pend = 1;
      end
      out_ready = 1'($urandom_range(1));
      if (out_valid && out_ready) begin
        xq = 99999; xr = 99999;
        if (eq.size() > 0) begin xq = eq.pop_front(); xr = er.pop_front(); end
        total++; if (out_quotient !== W'(xq) || out_remainder !== W'(xr) || out_ovf !== 1'b0) begin
          bad++; $display("FAIL b2b_item%0d got q=%0d r=%0d exp %0d/%0d", recv, out_quotient, out_remainder, xq, xr);
        end
        recv++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++; if (recv != N || sent != N || eq.size() != 0) begin
      bad++; $display("FAIL b2b_count got recv=%0d sent=%0d left=%0d exp %0d/%0d/0", recv, sent, eq.size(), N, N);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    out_ready = 1'b0;
    issue(3, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 ||
                 out_quotient !== 16'sd0 || div_divident !== 16'sd0 || out_ovf !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got v=%b rdy=%b busy=%b q=%0d dd=%0d exp all 0",
                      out_valid, in_ready, busy, out_quotient, div_divident);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < SC + 4; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    total++; if (seen || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_abort got seen=%b rdy=%b busy=%b exp 0/1/0", seen, in_ready, busy);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_ovf;
    test_zero;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
